lv_hv_rd_sched: RTL and testbench
=================================

# lv_hv_rd_sched

Low-voltage-side scheduler that owns the one-wire (OWT) read channel to the HV die. It shares the channel between a periodic HV ADC poll and on-demand SPI reads of HV registers. For each read it issues the command, supervises the reply with a timeout, and retries on failure. ADC replies land in the LV shadow ADC registers through the OWT RX path; SPI replies return to the SPI register front end.

## Interface
- OWT_CMD_BIT_NUM, 8, OWT command width; MSB = read flag, low bits = HV register address
- OWT_ADCD_BIT_NUM, 20, OWT reply data width (two packed ADC words)
- REG_AW, 7, HV register address width (= OWT_CMD_BIT_NUM-1)
- ADC_ADDR, 7'h1F, HV address of the ADC data register
- POLL_PERIOD, 1000, clocks between ADC poll requests (>= 2)
- RX_TMO, 64, clocks allowed from command acceptance to reply (>= 2)
- MAX_RETRY, 2, retries after the first attempt (0..7)
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_poll_en  in  1  enables the periodic ADC poll
- i_spi_rd_req  in  1  SPI read request, level, held until o_spi_rd_ack
- i_spi_rd_addr  in  REG_AW  SPI target address, stable while requested
- o_spi_rd_ack  out  1  one-cycle completion pulse
- o_spi_rd_data  out  OWT_ADCD_BIT_NUM  reply data, valid with ack
- o_spi_rd_err  out  1  failure after all retries, valid with ack
- o_owt_tx_req  out  1  command request to OWT TX
- o_owt_tx_cmd  out  OWT_CMD_BIT_NUM  {1'b1, addr}
- i_owt_tx_gnt  in  1  TX accepted the command this cycle
- i_owt_rx_ack  in  1  reply received
- i_owt_rx_data  in  OWT_ADCD_BIT_NUM  reply data
- i_owt_rx_status  in  1  0 normal, 1 error (CRC or frame)
- o_adc_upd  out  1  one-cycle pulse: ADC poll succeeded
- o_hv_comm_err  out  1  level: the last transaction exhausted its retries

## Operation
- Poll timer: counts 0..POLL_PERIOD-1 while i_poll_en = 1. At terminal count it sets poll_pend and wraps to 0. Dropping i_poll_en clears the timer but not poll_pend. A terminal count while poll_pend is already set is lost; there is no queue.
- Arbitration happens in IDLE only, 2-way round robin. When both poll_pend and i_spi_rd_req are pending, the source not served last wins. After reset, SPI has priority.
- FSM states:
  - IDLE → SEND when any request is pending. The winner's address is latched and retry_cnt is cleared.
  - SEND: o_owt_tx_req = 1 with the latched command. On req & gnt → WAIT_RX, tmo_cnt = 0.
  - WAIT_RX:
    - i_owt_rx_ack with status 0 → OK.
    - ack with status 1, or tmo_cnt == RX_TMO-1 without ack → FAIL.
  - OK: clears o_hv_comm_err, then → IDLE.
    - Poll source: o_adc_upd pulses and poll_pend clears.
    - SPI source: o_spi_rd_ack pulses with o_spi_rd_data = latched rx data and err = 0.
  - FAIL:
    - retry_cnt < MAX_RETRY → retry_cnt++, → SEND with the same command.
    - Otherwise: o_hv_comm_err set, source completed (SPI ack with err = 1; poll_pend cleared, no o_adc_upd), → IDLE.
- i_owt_rx_ack outside WAIT_RX is ignored.
- If ack and timeout occur in the same cycle, ack wins.
- SPI deasserting its request mid-transaction does not abort it; the ack is still issued.
- Reset mid-transaction: FSM → IDLE, pending request and counters cleared, o_owt_tx_req drops asynchronously.

## Timing
- Reset values: all outputs 0; o_owt_tx_cmd = 0; FSM IDLE; last-served = poll.
- Request pending in IDLE at cycle N → o_owt_tx_req = 1 from N+1.
- Grant at cycle M → WAIT_RX from M+1; the timeout fires at M+RX_TMO if no ack arrives.
- Ack at cycle K → o_spi_rd_ack or o_adc_upd at K+1; IDLE at K+2. The next transaction can start o_owt_tx_req at K+3.
- A retry re-asserts o_owt_tx_req 2 cycles after the failing event.
- All outputs are registered. o_spi_rd_data holds its value until the next SPI completion.

## Structure
- Shared package lv_owt_pkg: OWT width constants and typedef enum for states {IDLE, SEND, WAIT_RX, OK, FAIL}. It is reused by the OWT TX/RX blocks.
- Sub-module lv_hv_rd_arb: 2-requester round-robin arbiter (req[1:0], update strobe, one-hot grant). The poll timer, FSM, retry and timeout counters stay in the top.

## Test plan
- ADC poll, POLL_PERIOD = 10, i_poll_en = 1, gnt the same cycle, ack with status 0 three cycles later → tx_cmd = 8'h9F, o_adc_upd pulses once, the next poll request 10 clocks after the previous terminal count.
- SPI read of address 7'h05, reply 20'hABCDE → tx_cmd = 8'h85, o_spi_rd_ack 1 cycle after ack with data 20'hABCDE, err = 0.
- Simultaneous SPI and poll pending from reset → SPI served first, then poll, then SPI again if still requested (alternation).
- No reply, RX_TMO = 8, MAX_RETRY = 2 → 3 tx commands each separated by a timeout; o_spi_rd_ack with err = 1; o_hv_comm_err = 1. It clears after the next good read.
- First reply with status = 1, second good → exactly 2 grants, err = 0, o_hv_comm_err stays 0.
- i_rst_n low during WAIT_RX → outputs 0 immediately; a late ack after reset release is ignored; no spurious ack.

Source files
------------

// File: rtl/lv_owt_pkg.sv
// Shared one-wire (OWT) constants and read-scheduler state encoding.
// Reused by the OWT TX/RX blocks and the HV read scheduler.
package lv_owt_pkg;

  localparam int OWT_CMD_BIT_NUM  = 8;
  localparam int OWT_ADCD_BIT_NUM = 20;
  localparam int REG_AW           = OWT_CMD_BIT_NUM - 1;

  localparam logic [REG_AW-1:0] ADC_ADDR = 7'h1F;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RX,
    OK,
    FAIL
  } owt_rd_state_e;

endpackage

// File: rtl/lv_hv_rd_arb.sv
// 2-requester round-robin arbiter; bit 0 = SPI, bit 1 = ADC poll.
// Latency: combinational grant, last-served updated on i_upd.
// Backpressure: none, grant is only consumed when the caller strobes i_upd.
module lv_hv_rd_arb (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic [1:0] o_gnt
);

  // 1 when requester 1 (poll) was served last; reset value gives SPI priority
  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[0] && (!i_req[1] || r_last)) begin
      o_gnt = 2'b01;
    end else if (i_req[1]) begin
      o_gnt = 2'b10;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (i_upd && (o_gnt != 2'b00)) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/lv_hv_rd_sched.sv
// Shares the OWT read channel between the periodic ADC poll and SPI register reads.
// Latency: tx_req 1 clk after a pending request in IDLE; completion 1 clk after a good reply.
// Backpressure: command held on o_owt_tx_req until i_owt_tx_gnt; SPI request held until ack.
module lv_hv_rd_sched
  import lv_owt_pkg::*;
#(
  parameter int POLL_PERIOD = 1000,
  parameter int RX_TMO      = 64,
  parameter int MAX_RETRY   = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_poll_en,
  input  logic                        i_spi_rd_req,
  input  logic [REG_AW-1:0]           i_spi_rd_addr,
  output logic                        o_spi_rd_ack,
  output logic [OWT_ADCD_BIT_NUM-1:0] o_spi_rd_data,
  output logic                        o_spi_rd_err,
  output logic                        o_owt_tx_req,
  output logic [OWT_CMD_BIT_NUM-1:0]  o_owt_tx_cmd,
  input  logic                        i_owt_tx_gnt,
  input  logic                        i_owt_rx_ack,
  input  logic [OWT_ADCD_BIT_NUM-1:0] i_owt_rx_data,
  input  logic                        i_owt_rx_status,
  output logic                        o_adc_upd,
  output logic                        o_hv_comm_err
);

  localparam int PCW = $clog2(POLL_PERIOD);
  localparam int TCW = $clog2(RX_TMO);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_PERIOD - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(RX_TMO - 1);
  localparam logic [2:0]     MAX_R     = 3'(MAX_RETRY);

  owt_rd_state_e               r_state;
  logic [PCW-1:0]              r_poll_cnt;
  logic                        r_poll_pend;
  logic                        r_src_poll;
  logic [2:0]                  r_retry;
  logic [TCW-1:0]              r_tmo;
  logic                        r_spi_ack;
  logic [OWT_ADCD_BIT_NUM-1:0] r_spi_data;
  logic                        r_spi_err;
  logic                        r_tx_req;
  logic [OWT_CMD_BIT_NUM-1:0]  r_tx_cmd;
  logic                        r_adc_upd;
  logic                        r_comm_err;

  logic                        w_poll_tc;
  logic [1:0]                  w_req;
  logic [1:0]                  w_gnt;
  logic                        w_arb_upd;

  assign w_poll_tc = i_poll_en && (r_poll_cnt == POLL_LAST);
  assign w_req     = {r_poll_pend, i_spi_rd_req};
  assign w_arb_upd = (r_state == IDLE) && (w_req != 2'b00);

  lv_hv_rd_arb u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (w_req),
    .i_upd   (w_arb_upd),
    .o_gnt   (w_gnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_poll_cnt <= '0;
    end else if (!i_poll_en || w_poll_tc) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_poll_pend <= 1'b0;
      r_src_poll  <= 1'b0;
      r_retry     <= '0;
      r_tmo       <= '0;
      r_spi_ack   <= 1'b0;
      r_spi_data  <= '0;
      r_spi_err   <= 1'b0;
      r_tx_req    <= 1'b0;
      r_tx_cmd    <= '0;
      r_adc_upd   <= 1'b0;
      r_comm_err  <= 1'b0;
    end else begin
      r_spi_ack <= 1'b0;
      r_adc_upd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req != 2'b00) begin
            r_state    <= SEND;
            r_src_poll <= w_gnt[1];
            r_retry    <= '0;
            r_tx_req   <= 1'b1;
            r_tx_cmd   <= {1'b1, (w_gnt[1] ? ADC_ADDR : i_spi_rd_addr)};
          end
        end
        SEND: begin
          if (i_owt_tx_gnt) begin
            r_tx_req <= 1'b0;
            r_tmo    <= '0;
            r_state  <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          // a reply in the timeout cycle still counts as a reply
          if (i_owt_rx_ack && !i_owt_rx_status) begin
            r_state    <= OK;
            r_comm_err <= 1'b0;
            if (r_src_poll) begin
              r_adc_upd   <= 1'b1;
              r_poll_pend <= 1'b0;
            end else begin
              r_spi_ack  <= 1'b1;
              r_spi_err  <= 1'b0;
              r_spi_data <= i_owt_rx_data;
            end
          end else if (i_owt_rx_ack || (r_tmo == TMO_LAST)) begin
            r_state <= FAIL;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        OK: begin
          r_state <= IDLE;
        end
        FAIL: begin
          if (r_retry < MAX_R) begin
            r_retry  <= r_retry + 1'b1;
            r_tx_req <= 1'b1;
            r_state  <= SEND;
          end else begin
            r_comm_err <= 1'b1;
            r_state    <= IDLE;
            if (r_src_poll) begin
              r_poll_pend <= 1'b0;
            end else begin
              r_spi_ack <= 1'b1;
              r_spi_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // a fresh terminal count outranks the completion clearing the old poll
      if (w_poll_tc) begin
        r_poll_pend <= 1'b1;
      end
    end
  end

  assign o_spi_rd_ack  = r_spi_ack;
  assign o_spi_rd_data = r_spi_data;
  assign o_spi_rd_err  = r_spi_err;
  assign o_owt_tx_req  = r_tx_req;
  assign o_owt_tx_cmd  = r_tx_cmd;
  assign o_adc_upd     = r_adc_upd;
  assign o_hv_comm_err = r_comm_err;

endmodule

// File: tb/tb_lv_hv_rd_sched.sv
// Bench for lv_hv_rd_sched: acts as SPI master and OWT TX/RX peer, checks against a
// transaction-level model of attempts, retries, timeouts and round-robin order.
module tb_lv_hv_rd_sched;

  localparam int POLL_PERIOD = 10;
  localparam int RX_TMO      = 8;
  localparam int MAX_RETRY   = 2;
  localparam int K_GOOD = 0, K_BAD = 1, K_NONE = 2;

  logic        i_clk, i_rst_n, i_poll_en, i_spi_rd_req;
  logic [6:0]  i_spi_rd_addr;
  logic        o_spi_rd_ack, o_spi_rd_err, o_owt_tx_req, o_adc_upd, o_hv_comm_err;
  logic [19:0] o_spi_rd_data, i_owt_rx_data;
  logic [7:0]  o_owt_tx_cmd;
  logic        i_owt_tx_gnt, i_owt_rx_ack, i_owt_rx_status;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // per-attempt plan for the OWT peer: reply kind, grant delay, reply delay, data
  int          p_kind [3];
  int          p_gdly [3];
  int          p_rdly [3];
  logic [19:0] p_rdat [3];
  bit          m_comm_err;
  logic [19:0] m_spi_data;

  lv_hv_rd_sched #(
    .POLL_PERIOD (POLL_PERIOD),
    .RX_TMO      (RX_TMO),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_poll_en       (i_poll_en),
    .i_spi_rd_req    (i_spi_rd_req),
    .i_spi_rd_addr   (i_spi_rd_addr),
    .o_spi_rd_ack    (o_spi_rd_ack),
    .o_spi_rd_data   (o_spi_rd_data),
    .o_spi_rd_err    (o_spi_rd_err),
    .o_owt_tx_req    (o_owt_tx_req),
    .o_owt_tx_cmd    (o_owt_tx_cmd),
    .i_owt_tx_gnt    (i_owt_tx_gnt),
    .i_owt_rx_ack    (i_owt_rx_ack),
    .i_owt_rx_data   (i_owt_rx_data),
    .i_owt_rx_status (i_owt_rx_status),
    .o_adc_upd       (o_adc_upd),
    .o_hv_comm_err   (o_hv_comm_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  function automatic logic [63:0] out_vec();
    return {31'd0, o_owt_tx_req, o_owt_tx_cmd, o_spi_rd_ack, o_spi_rd_data,
            o_spi_rd_err, o_adc_upd, o_hv_comm_err};
  endfunction

  task automatic set_plan(input int a, input int k, input int g, input int r, input logic [19:0] d);
    p_kind[a] = k;
    p_gdly[a] = g;
    p_rdly[a] = r;
    p_rdat[a] = d;
  endtask

  task automatic rand_plan();
    for (int a = 0; a < 3; a++) begin
      int r;
      r = $urandom_range(0, 3);
      set_plan(a, (r < 2) ? K_GOOD : ((r == 2) ? K_BAD : K_NONE),
               $urandom_range(0, 3), $urandom_range(1, RX_TMO), 20'($urandom));
    end
  endtask

  task automatic wait_tx_req();
    int n;
    n = 0;
    while (o_owt_tx_req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (o_owt_tx_req !== 1'b1) begin
      chk("tx_req_wait", o_owt_tx_req, 1);
      finish_run();
    end
  endtask

  task automatic idle_chk(input string tag);
    step();
    step();
    chk(tag, o_owt_tx_req, 0);
  endtask

  // One full read as seen from the OWT side; outcome follows the plan:
  // the first good reply among MAX_RETRY+1 attempts completes it, else it errors.
  task automatic run_txn(input bit src_poll, input logic [7:0] exp_cmd,
                         input bit keep_spi, input bit drop_poll);
    bit done;
    done = 1'b0;
    for (int a = 0; a <= MAX_RETRY && !done; a++) begin
      wait_tx_req();
      chk("tx_cmd", o_owt_tx_cmd, exp_cmd);
      for (int i = 0; i < p_gdly[a]; i++) begin
        i_owt_rx_ack  = 1'($urandom_range(0, 1));
        i_owt_rx_data = 20'($urandom);
        step();
      end
      if (p_gdly[a] > 0) chk("req_hold", o_owt_tx_req, 1);
      i_owt_rx_ack = 1'b0;
      i_owt_tx_gnt = 1'b1;
      step();
      i_owt_tx_gnt = 1'b0;
      chk("req_drop", o_owt_tx_req, 0);
      if (p_kind[a] == K_NONE) begin
        for (int i = 1; i < RX_TMO; i++) step();
        step();
        chk("tmo_edge", o_owt_tx_req, 0);
        step();
      end else begin
        for (int i = 1; i < p_rdly[a]; i++) step();
        i_owt_rx_ack    = 1'b1;
        i_owt_rx_status = (p_kind[a] == K_BAD);
        i_owt_rx_data   = p_rdat[a];
        step();
        i_owt_rx_ack    = 1'b0;
        i_owt_rx_status = 1'b0;
        if (p_kind[a] == K_GOOD) begin
          done = 1'b1;
          m_comm_err = 1'b0;
          chk("done_ok", {o_spi_rd_ack, o_adc_upd}, src_poll ? 2'b01 : 2'b10);
          if (!src_poll) begin
            chk("rd_data", o_spi_rd_data, p_rdat[a]);
            chk("rd_err_ok", o_spi_rd_err, 0);
            m_spi_data   = p_rdat[a];
            i_spi_rd_req = keep_spi;
          end else if (drop_poll) begin
            i_poll_en = 1'b0;
          end
          chk("comm_err_ok", o_hv_comm_err, m_comm_err);
        end else begin
          chk("no_ack_bad", {o_spi_rd_ack, o_adc_upd}, 0);
          step();
        end
      end
      if (!done) begin
        if (a < MAX_RETRY) begin
          chk("retry_req", o_owt_tx_req, 1);
        end else begin
          m_comm_err = 1'b1;
          chk("done_fail", {o_spi_rd_ack, o_adc_upd}, src_poll ? 2'b00 : 2'b10);
          if (!src_poll) begin
            chk("rd_err_fail", o_spi_rd_err, 1);
            i_spi_rd_req = keep_spi;
          end else if (drop_poll) begin
            i_poll_en = 1'b0;
          end
          chk("comm_err_fail", o_hv_comm_err, m_comm_err);
        end
      end
    end
    step();
    chk("pulse_end", {o_spi_rd_ack, o_adc_upd}, 0);
  endtask

  initial begin
    int t0, t_req, cnt;
    i_rst_n = 1'b0; i_poll_en = 1'b0; i_spi_rd_req = 1'b0; i_spi_rd_addr = '0;
    i_owt_tx_gnt = 1'b0; i_owt_rx_ack = 1'b0; i_owt_rx_data = '0; i_owt_rx_status = 1'b0;
    m_comm_err = 1'b0; m_spi_data = '0;
    step();
    chk("reset_outs", out_vec(), 0);
    step();
    i_rst_n = 1'b1;
    step();

    // poll timer: a short enable burst must not carry over once poll_en drops
    i_poll_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    i_poll_en = 1'b0;
    step();
    i_poll_en = 1'b1;
    t0 = cyc;
    wait_tx_req();
    chk("poll_first", cyc - t0, POLL_PERIOD + 1);
    t_req = cyc;
    set_plan(0, K_GOOD, 0, 3, 20'h12345);
    run_txn(1'b1, 8'h9F, 1'b0, 1'b0);
    wait_tx_req();
    chk("poll_period", cyc - t_req, POLL_PERIOD);
    run_txn(1'b1, 8'h9F, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 2 * POLL_PERIOD; i++) begin
      step();
      if (o_owt_tx_req) cnt++;
    end
    chk("poll_off_idle", cnt, 0);

    // SPI read of 0x05
    i_spi_rd_addr = 7'h05;
    i_spi_rd_req  = 1'b1;
    t0 = cyc;
    wait_tx_req();
    chk("req_latency", cyc - t0, 1);
    set_plan(0, K_GOOD, 0, 2, 20'hABCDE);
    run_txn(1'b0, 8'h85, 1'b0, 1'b0);
    idle_chk("idle_spi");

    // status error then a good reply landing exactly on the timeout cycle
    i_spi_rd_addr = 7'h33;
    i_spi_rd_req  = 1'b1;
    set_plan(0, K_BAD, 1, 3, 20'h0F0F0);
    set_plan(1, K_GOOD, 0, RX_TMO, 20'h5A5A5);
    run_txn(1'b0, 8'hB3, 1'b0, 1'b0);
    idle_chk("two_grants");

    // silence on every attempt, then a good read clears the sticky error
    i_spi_rd_addr = 7'h11;
    i_spi_rd_req  = 1'b1;
    for (int a = 0; a < 3; a++) set_plan(a, K_NONE, 0, 1, 20'h0);
    run_txn(1'b0, 8'h91, 1'b0, 1'b0);
    idle_chk("idle_fail");
    i_spi_rd_req = 1'b1;
    set_plan(0, K_GOOD, 2, 4, 20'h76543);
    run_txn(1'b0, 8'h91, 1'b0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      logic [6:0] addr;
      addr = 7'($urandom);
      i_spi_rd_addr = addr;
      i_spi_rd_req  = 1'b1;
      rand_plan();
      run_txn(1'b0, {1'b1, addr}, 1'b0, 1'b0);
      idle_chk("idle_rand");
    end

    // reset while waiting for a reply, with the sticky error set
    i_spi_rd_addr = 7'h44;
    i_spi_rd_req  = 1'b1;
    for (int a = 0; a < 3; a++) set_plan(a, K_NONE, 0, 1, 20'h0);
    run_txn(1'b0, 8'hC4, 1'b0, 1'b0);
    i_spi_rd_req = 1'b1;
    wait_tx_req();
    i_owt_tx_gnt = 1'b1;
    step();
    i_owt_tx_gnt = 1'b0;
    step();
    #2;
    i_rst_n = 1'b0;
    i_spi_rd_req = 1'b0;
    #1;
    chk("rst_async_wait", out_vec(), 0);
    m_comm_err = 1'b0;
    m_spi_data = '0;
    step();
    i_rst_n = 1'b1;
    step();
    i_owt_rx_ack  = 1'b1;
    i_owt_rx_data = 20'hDEAD1;
    step();
    i_owt_rx_ack = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_spi_rd_ack || o_adc_upd || o_owt_tx_req) cnt++;
    end
    chk("late_ack_ignored", cnt, 0);

    // reset while the command is still being offered
    i_spi_rd_addr = 7'h22;
    i_spi_rd_req  = 1'b1;
    wait_tx_req();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_async_send", o_owt_tx_req, 0);
    i_spi_rd_req = 1'b0;
    step();
    i_rst_n = 1'b1;
    step();

    // both sources pending from reset: SPI, poll, SPI, poll, SPI
    i_poll_en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    i_spi_rd_addr = 7'h2A;
    i_spi_rd_req  = 1'b1;
    set_plan(0, K_GOOD, 0, 1, 20'h13579);
    run_txn(1'b0, 8'hAA, 1'b1, 1'b0);
    set_plan(0, K_GOOD, 0, 1, 20'h2468A);
    run_txn(1'b1, 8'h9F, 1'b0, 1'b0);
    chk("data_hold", o_spi_rd_data, m_spi_data);
    set_plan(0, K_GOOD, 0, 1, 20'h0BEEF);
    run_txn(1'b0, 8'hAA, 1'b1, 1'b0);
    set_plan(0, K_GOOD, 0, 1, 20'h11111);
    run_txn(1'b1, 8'h9F, 1'b0, 1'b1);
    set_plan(0, K_GOOD, 0, 1, 20'hC0FFE);
    run_txn(1'b0, 8'hAA, 1'b0, 1'b0);
    idle_chk("idle_arb");

    finish_run();
  end

endmodule
